fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Produces the operand-forwarding selects EX_MEM_A, MEM_WB_A, EX_MEM_B and MEM_WB_B that the execute stage consumes, plus the load-use stall.
- Tracks destination tags of the instructions in the EX and MEM slots in an internal shadow pipeline.
- Compares those tags against the decode-stage sources, then registers the selects so they are valid during the consumer's EX cycle.
- Sits between decode and the ID/EX pipeline register.

Parameters:
- REG_AW, 3, register-address width (8 GPRs).
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs  in  REG_AW  source A register.
- id_rt  in  REG_AW  source B register.
- id_use_rs  in  1  instruction reads rs (ALU operand A).
- id_use_rt  in  1  instruction reads rt (ALU operand B or store data).
- id_rd  in  REG_AW  destination register.
- id_reg_write  in  1  instruction writes id_rd.
- id_is_load  in  1  instruction is LD.
- flush  in  1  taken branch/jump; kills the decode slot.
- freeze  in  1  memory stall; whole pipeline holds.
- stall  out  1  combinational load-use stall to fetch/decode.
- EX_MEM_A  out  1  operand A from EX/MEM result.
- MEM_WB_A  out  1  operand A from MEM/WB result.
- EX_MEM_B  out  1  operand B/store data from EX/MEM result.
- MEM_WB_B  out  1  operand B/store data from MEM/WB result.

Behaviour:
- Shadow state: ex_{v,rd,wr,ld} and mem_{v,rd,wr}. All clear on reset. All four select outputs reset to 0.
- Reset is asynchronous and active-low: rst_n low clears all state and outputs immediately, including mid-stall.
- Match terms:
  - hitEx(s) = ex_v & ex_wr & ex_rd==s.
  - hitMem(s) = mem_v & mem_wr & mem_rd==s.
- Register 0 is an ordinary GPR; no special casing.
- stall = id_valid & ~flush & ~freeze & ex_ld & ((id_use_rs & hitEx(rs)) | (id_use_rt & hitEx(rt))).
- Per rising edge, priority freeze > stall > normal:
  - freeze=1: all state and outputs hold.
  - stall=1: ex slot becomes a bubble (v=0); mem <= ex; all selects <= 0.
  - normal:
    - mem <= ex.
    - ex <= id fields, with ex_v = id_valid & ~flush.
    - EX_MEM_A <= id_use_rs & hitEx(rs).
    - MEM_WB_A <= id_use_rs & hitMem(rs) & ~hitEx(rs), so the younger producer wins.
    - B selects: same rules using rt.
    - When flush=1 or id_valid=0, all selects <= 0.
- Latency: selects are registered one cycle after the decode compare and align with the consumer's EX cycle. stall has zero latency.
- A load-use stall lasts exactly one cycle. The next cycle the load sits in mem, and the held instruction receives MEM_WB_x.
- Producers that reach WB while the consumer is in ID rely on register-file write-before-read bypass. Not tracked here.
- A producer with wr=0 (store, branch) never generates a hit.
- Both sources may match the same producer; both selects assert.
- Simultaneous flush and load hazard: flush wins, stall=0, bubble inserted.

Optional Feature:
- Macro FWD_STATS_EN.
- Defined:
  - Adds outputs fwd_count [CNT_W] and stall_count [CNT_W].
  - fwd_count increments on each non-freeze edge where any select is loaded as 1 (one count per instruction, not per select).
  - stall_count increments on each edge with stall=1 and freeze=0.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Back-to-back ADD r1 then ADD r2,r1,r3 (rs=1) -> one cycle later EX_MEM_A=1, others 0, stall never asserts.
- Producer r1, one independent instruction, then a consumer with rt=1 -> MEM_WB_B=1, EX_MEM_B=0.
- Two writers of r4 in a row, then a consumer of r4 on both sources -> EX_MEM_A=EX_MEM_B=1, MEM_WB_A=MEM_WB_B=0.
- LD r5 then ADD using rs=5:
  - stall=1 for exactly one cycle, with selects 0 that cycle.
  - Next EX cycle shows MEM_WB_A=1.
- Hazard cases with freeze held 3 cycles mid-sequence, and with flush asserted during a load-use hazard:
  - Freeze: outputs and state frozen.
  - Flush: stall=0 and the following selects are 0.
- rst_n pulled low during a stall cycle -> all outputs 0 immediately, with no clock edge required. With FWD_STATS_EN: counters read 0.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
//   Operand-forwarding and load-use hazard control. It sits between decode and the
//   ID/EX pipeline register. A small shadow pipeline follows the destination tags of the
//   instructions in the EX and MEM slots. Those tags are compared against the decode-stage
//   sources. The forwarding selects are registered so that they are valid during the
//   consumer's EX cycle. The load-use stall is combinational.
//
//   Optional build macro: FWD_STATS_EN adds saturating forward/stall statistics counters.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   id_valid            decode slot holds a real instruction
//   id_rs, id_rt        source A / source B register addresses
//   id_use_rs/rt        instruction actually reads rs / rt
//   id_rd, id_reg_write destination register and its write enable
//   id_is_load          instruction is a load
//   flush               taken branch/jump, kills the decode slot
//   freeze              memory stall, whole pipeline holds
//   stall               load-use stall to fetch/decode (zero latency)
//   EX_MEM_A, MEM_WB_A  operand A forward selects (registered)
//   EX_MEM_B, MEM_WB_B  operand B / store-data forward selects (registered)
//   fwd_count           (FWD_STATS_EN) instructions that received any forward
//   stall_count         (FWD_STATS_EN) load-use stall cycles taken
module fwd_hazard_ctrl #(
   parameter int unsigned REG_AW = 3,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_is_load,
   input  logic              flush,
   input  logic              freeze,
   output logic              stall,
   output logic              EX_MEM_A,
   output logic              MEM_WB_A,
   output logic              EX_MEM_B,
   output logic              MEM_WB_B
`ifdef FWD_STATS_EN
   ,
   output logic [CNT_W-1:0]  fwd_count,
   output logic [CNT_W-1:0]  stall_count
`endif
);

   // Shadow pipeline: instruction in EX and instruction in MEM.
   logic              ex_v, ex_wr, ex_ld;
   logic [REG_AW-1:0] ex_rd;
   logic              mem_v, mem_wr;
   logic [REG_AW-1:0] mem_rd;

   logic hit_ex_rs, hit_ex_rt, hit_mem_rs, hit_mem_rt;
   logic id_live;
   logic ex_mem_a_d, mem_wb_a_d, ex_mem_b_d, mem_wb_b_d;

   always_comb begin
      hit_ex_rs  = ex_v & ex_wr & (ex_rd == id_rs);
      hit_ex_rt  = ex_v & ex_wr & (ex_rd == id_rt);
      hit_mem_rs = mem_v & mem_wr & (mem_rd == id_rs);
      hit_mem_rt = mem_v & mem_wr & (mem_rd == id_rt);

      id_live = id_valid & ~flush;

      stall = id_live & ~freeze & ex_ld &
              ((id_use_rs & hit_ex_rs) | (id_use_rt & hit_ex_rt));

      // The younger producer (EX) takes precedence over the older one (MEM).
      ex_mem_a_d = id_live & id_use_rs & hit_ex_rs;
      mem_wb_a_d = id_live & id_use_rs & hit_mem_rs & ~hit_ex_rs;
      ex_mem_b_d = id_live & id_use_rt & hit_ex_rt;
      mem_wb_b_d = id_live & id_use_rt & hit_mem_rt & ~hit_ex_rt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_v     <= 1'b0;
         ex_rd    <= '0;
         ex_wr    <= 1'b0;
         ex_ld    <= 1'b0;
         mem_v    <= 1'b0;
         mem_rd   <= '0;
         mem_wr   <= 1'b0;
         EX_MEM_A <= 1'b0;
         MEM_WB_A <= 1'b0;
         EX_MEM_B <= 1'b0;
         MEM_WB_B <= 1'b0;
      end else if (!freeze) begin
         mem_v  <= ex_v;
         mem_rd <= ex_rd;
         mem_wr <= ex_wr;
         if (stall) begin
            // Decode is held; a bubble enters EX behind the load.
            ex_v     <= 1'b0;
            ex_wr    <= 1'b0;
            ex_ld    <= 1'b0;
            EX_MEM_A <= 1'b0;
            MEM_WB_A <= 1'b0;
            EX_MEM_B <= 1'b0;
            MEM_WB_B <= 1'b0;
         end else begin
            ex_v     <= id_live;
            ex_rd    <= id_rd;
            ex_wr    <= id_reg_write;
            ex_ld    <= id_is_load;
            EX_MEM_A <= ex_mem_a_d;
            MEM_WB_A <= mem_wb_a_d;
            EX_MEM_B <= ex_mem_b_d;
            MEM_WB_B <= mem_wb_b_d;
         end
      end
   end

`ifdef FWD_STATS_EN
   logic any_fwd;

   // Selects can only load a 1 on a normal (non-stall) edge; stall already excludes freeze.
   assign any_fwd = ~stall & (ex_mem_a_d | mem_wb_a_d | ex_mem_b_d | mem_wb_b_d);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_count   <= '0;
         stall_count <= '0;
      end else if (!freeze) begin
         if (any_fwd && !(&fwd_count)) begin
            fwd_count <= fwd_count + 1'b1;
         end
         if (stall && !(&stall_count)) begin
            stall_count <= stall_count + 1'b1;
         end
      end
   end
`else
   // Counter width is only meaningful when statistics are built in.
   logic [CNT_W-1:0] unused_cnt_w;
   assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;

   localparam int unsigned REG_AW = 3;
   localparam int unsigned CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              id_valid = 1'b0;
   logic [REG_AW-1:0] id_rs = '0;
   logic [REG_AW-1:0] id_rt = '0;
   logic              id_use_rs = 1'b0;
   logic              id_use_rt = 1'b0;
   logic [REG_AW-1:0] id_rd = '0;
   logic              id_reg_write = 1'b0;
   logic              id_is_load = 1'b0;
   logic              flush = 1'b0;
   logic              freeze = 1'b0;
   logic              stall;
   logic              EX_MEM_A, MEM_WB_A, EX_MEM_B, MEM_WB_B;
`ifdef FWD_STATS_EN
   logic [CNT_W-1:0]  fwd_count, stall_count;
   int                exp_fwd = 0;
   int                exp_stall_cnt = 0;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // Expected select vectors {EX_MEM_A, MEM_WB_A, EX_MEM_B, MEM_WB_B}.
   logic [3:0] sb[$];

   fwd_hazard_ctrl #(
      .REG_AW (REG_AW),
      .CNT_W  (CNT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_use_rs    (id_use_rs),
      .id_use_rt    (id_use_rt),
      .id_rd        (id_rd),
      .id_reg_write (id_reg_write),
      .id_is_load   (id_is_load),
      .flush        (flush),
      .freeze       (freeze),
      .stall        (stall),
      .EX_MEM_A     (EX_MEM_A),
      .MEM_WB_A     (MEM_WB_A),
      .EX_MEM_B     (EX_MEM_B),
      .MEM_WB_B     (MEM_WB_B)
`ifdef FWD_STATS_EN
      ,
      .fwd_count    (fwd_count),
      .stall_count  (stall_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [3:0] sels();
      return {EX_MEM_A, MEM_WB_A, EX_MEM_B, MEM_WB_B};
   endfunction

   // One decode cycle: drive, check stall, push expected selects, clock, pop and compare.
   task automatic step(input string tag, input logic v, input logic [2:0] rs, input logic [2:0] rt,
                       input logic urs, input logic urt, input logic [2:0] rd, input logic wr,
                       input logic ld, input logic fl, input logic fz,
                       input logic exp_stall, input logic [3:0] exp_sel);
      logic [3:0] exp;
      @(negedge clk);
      id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
      id_rd = rd; id_reg_write = wr; id_is_load = ld; flush = fl; freeze = fz;
      #1;
      check_eq({tag, ".stall"}, {31'd0, stall}, {31'd0, exp_stall});
      sb.push_back(exp_sel);
`ifdef FWD_STATS_EN
      if (!fz && exp_sel != 4'b0000) exp_fwd++;
      if (exp_stall) exp_stall_cnt++;
`endif
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      check_eq({tag, ".sel"}, {28'd0, sels()}, {28'd0, exp});
   endtask

   task automatic nop();
      step("nop", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst.sel", {28'd0, sels()}, 32'd0);
      check_eq("rst.stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back ALU dependency on rs.
      step("add_r1",   1, 3'd2, 3'd3, 1, 1, 3'd1, 1, 0, 0, 0, 0, 4'b0000);
      step("dep_rs",   1, 3'd1, 3'd3, 1, 1, 3'd2, 1, 0, 0, 0, 0, 4'b1000);
      nop(); nop();

      // Producer, independent, consumer on rt -> MEM/WB forward.
      step("prod_r1",  1, 3'd0, 3'd0, 0, 0, 3'd1, 1, 0, 0, 0, 0, 4'b0000);
      step("indep",    1, 3'd6, 3'd7, 1, 1, 3'd7, 1, 0, 0, 0, 0, 4'b0000);
      step("dep_rt",   1, 3'd6, 3'd1, 1, 1, 3'd3, 1, 0, 0, 0, 0, 4'b0001);
      nop(); nop();

      // Two writers of r4; younger wins on both sources.
      step("w4a",      1, 3'd0, 3'd0, 0, 0, 3'd4, 1, 0, 0, 0, 0, 4'b0000);
      step("w4b",      1, 3'd0, 3'd0, 0, 0, 3'd4, 1, 0, 0, 0, 0, 4'b0000);
      step("dep_r4x2", 1, 3'd4, 3'd4, 1, 1, 3'd5, 1, 0, 0, 0, 0, 4'b1010);
      nop(); nop();

      // Load-use: one stall cycle, then MEM/WB forward.
      step("ld_r5",    1, 3'd0, 3'd0, 0, 0, 3'd5, 1, 1, 0, 0, 0, 4'b0000);
      step("lu_stall", 1, 3'd5, 3'd2, 1, 1, 3'd6, 1, 0, 0, 0, 1, 4'b0000);
      step("lu_retry", 1, 3'd5, 3'd2, 1, 1, 3'd6, 1, 0, 0, 0, 0, 4'b0100);
      nop(); nop();

      // Freeze holds outputs and state for three cycles.
      step("fz_w1",    1, 3'd0, 3'd0, 0, 0, 3'd1, 1, 0, 0, 0, 0, 4'b0000);
      step("fz_c1",    1, 3'd1, 3'd0, 1, 0, 3'd2, 1, 0, 0, 0, 0, 4'b1000);
      for (int i = 0; i < 3; i++)
         step("fz_hold", 1, 3'd1, 3'd0, 1, 0, 3'd3, 1, 0, 0, 1, 0, 4'b1000);
      step("fz_rel",   1, 3'd1, 3'd0, 1, 0, 3'd3, 1, 0, 0, 0, 0, 4'b0100);
      nop(); nop();

      // Freeze across a pending load-use hazard.
      step("fzl_ld",   1, 3'd0, 3'd0, 0, 0, 3'd5, 1, 1, 0, 0, 0, 4'b0000);
      for (int i = 0; i < 3; i++)
         step("fzl_hold", 1, 3'd5, 3'd2, 1, 1, 3'd6, 1, 0, 0, 1, 0, 4'b0000);
      step("fzl_stall", 1, 3'd5, 3'd2, 1, 1, 3'd6, 1, 0, 0, 0, 1, 4'b0000);
      step("fzl_retry", 1, 3'd5, 3'd2, 1, 1, 3'd6, 1, 0, 0, 0, 0, 4'b0100);
      nop(); nop();

      // Flush wins over a load-use hazard.
      step("fl_ld",    1, 3'd0, 3'd0, 0, 0, 3'd5, 1, 1, 0, 0, 0, 4'b0000);
      step("fl_kill",  1, 3'd5, 3'd0, 1, 0, 3'd6, 1, 0, 1, 0, 0, 4'b0000);
      step("fl_next",  1, 3'd5, 3'd0, 1, 0, 3'd6, 1, 0, 0, 0, 0, 4'b0100);
      nop(); nop();

      // Non-writing producer, invalid consumer, and r0 as an ordinary register.
      step("store",    1, 3'd0, 3'd0, 0, 0, 3'd3, 0, 0, 0, 0, 0, 4'b0000);
      step("st_cons",  1, 3'd3, 3'd3, 1, 1, 3'd0, 0, 0, 0, 0, 0, 4'b0000);
      step("prod_r2",  1, 3'd0, 3'd0, 0, 0, 3'd2, 1, 0, 0, 0, 0, 4'b0000);
      step("inv_cons", 0, 3'd2, 3'd2, 1, 1, 3'd0, 1, 0, 0, 0, 0, 4'b0000);
      nop(); nop();
      step("prod_r0",  1, 3'd1, 3'd1, 0, 0, 3'd0, 1, 0, 0, 0, 0, 4'b0000);
      step("cons_r0",  1, 3'd0, 3'd1, 1, 1, 3'd7, 1, 0, 0, 0, 0, 4'b1000);
      nop(); nop();

      // Reset asserted in the middle of a stall cycle with a select held high.
      step("rs_w1",    1, 3'd0, 3'd0, 0, 0, 3'd1, 1, 0, 0, 0, 0, 4'b0000);
      step("rs_ld",    1, 3'd1, 3'd0, 1, 0, 3'd5, 1, 1, 0, 0, 0, 4'b1000);
`ifdef FWD_STATS_EN
      check_eq("fwd_count", {16'd0, fwd_count}, exp_fwd);
      check_eq("stall_count", {16'd0, stall_count}, exp_stall_cnt);
`endif
      @(negedge clk);
      id_valid = 1; id_rs = 3'd5; id_rt = 3'd0; id_use_rs = 1; id_use_rt = 0;
      id_rd = 3'd6; id_reg_write = 1; id_is_load = 0; flush = 0; freeze = 0;
      #1;
      check_eq("pre_rst.stall", {31'd0, stall}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("async_rst.stall", {31'd0, stall}, 32'd0);
      check_eq("async_rst.sel", {28'd0, sels()}, 32'd0);
`ifdef FWD_STATS_EN
      check_eq("async_rst.fwd_count", {16'd0, fwd_count}, 32'd0);
      check_eq("async_rst.stall_count", {16'd0, stall_count}, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
